// File: rtl/m2_pixel_block_fetch_pkg.sv
// Shared constants and types for the encoder-side 8x8 pixel block fetcher.
package m2_pixel_block_fetch_pkg;

    localparam int unsigned ADDR_W          = 18;
    localparam int unsigned DP_ADDR_W       = 7;
    localparam int unsigned INDEX_W         = 12;

    localparam logic [17:0] Y_BASE_DEF      = 18'd0;
    localparam logic [17:0] U_BASE_DEF      = 18'd38400;
    localparam logic [17:0] V_BASE_DEF      = 18'd57600;

    localparam int unsigned Y_WPR           = 160;
    localparam int unsigned UV_WPR          = 80;
    localparam int unsigned Y_COLS          = 40;
    localparam int unsigned UV_COLS         = 20;
    localparam int unsigned ROWS            = 30;
    localparam int unsigned TOTAL_BLOCKS    = 2400;
    localparam int unsigned WORDS_PER_BLOCK = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_DRAIN,
        ST_PUBLISH,
        ST_WAIT_RELEASE
    } state_t;

    typedef enum logic [1:0] {
        SEG_Y,
        SEG_U,
        SEG_V,
        SEG_END
    } seg_t;

    // Pixel to DCT input: zero-extended, or (p - 128) sign-extended (p ^ 0x80 as signed byte).
    function automatic logic [31:0] pixel_value(input logic [7:0] p, input logic shift);
        return shift ? {{25{~p[7]}}, p[6:0]} : {24'd0, p};
    endfunction

endpackage

// File: rtl/m2_block_addr_gen.sv
// Block walker: seg/brow/bcol and r/k counters, SRAM word address and DPRAM address pair.
module m2_block_addr_gen
    import m2_pixel_block_fetch_pkg::*;
#(
    parameter logic [17:0] Y_BASE = Y_BASE_DEF,
    parameter logic [17:0] U_BASE = U_BASE_DEF,
    parameter logic [17:0] V_BASE = V_BASE_DEF
)(
    input  logic                 Clock,
    input  logic                 Resetn,
    input  logic                 issue,
    input  logic                 clear,
    input  logic                 buf_sel,
    output logic [ADDR_W-1:0]    sram_address,
    output logic [DP_ADDR_W-1:0] dp_address_a,
    output logic [DP_ADDR_W-1:0] dp_address_b,
    output logic [INDEX_W-1:0]   block_num
);

    logic [2:0]        r;
    logic [1:0]        k;
    logic [5:0]        bcol;
    logic [4:0]        brow;
    seg_t              seg;

    logic [ADDR_W-1:0] wpr_c;
    logic [ADDR_W-1:0] base_c;
    logic [ADDR_W-1:0] addr_c;
    logic [5:0]        last_col_c;

    // Address of the word (r,k) of the current block.
    always_comb begin
        wpr_c      = (seg == SEG_Y) ? 18'(Y_WPR) : 18'(UV_WPR);
        last_col_c = (seg == SEG_Y) ? 6'(Y_COLS - 1) : 6'(UV_COLS - 1);
        case (seg)
            SEG_Y:   base_c = Y_BASE;
            SEG_U:   base_c = U_BASE;
            default: base_c = V_BASE;
        endcase
        addr_c = base_c + 18'(brow) * (wpr_c << 3) + 18'({bcol, 2'b00})
               + 18'(r) * wpr_c + 18'(k);
    end

    // Issue one word per cycle; the last word of a block steps the block grid.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            sram_address <= '0;
            dp_address_a <= '0;
            dp_address_b <= '0;
            block_num    <= '0;
            r            <= '0;
            k            <= '0;
            bcol         <= '0;
            brow         <= '0;
            seg          <= SEG_Y;
        end else if (clear) begin
            block_num    <= '0;
            r            <= '0;
            k            <= '0;
            bcol         <= '0;
            brow         <= '0;
            seg          <= SEG_Y;
        end else if (issue) begin
            sram_address <= addr_c;
            dp_address_a <= {buf_sel, r, k, 1'b0};
            dp_address_b <= {buf_sel, r, k, 1'b1};
            k            <= k + 2'd1;
            if (k == 2'd3) begin
                r <= r + 3'd1;
                if (r == 3'd7) begin
                    block_num <= block_num + 12'd1;
                    if (bcol == last_col_c) begin
                        bcol <= '0;
                        if (brow == 5'(ROWS - 1)) begin
                            brow <= '0;
                            seg  <= seg_t'(seg + 2'd1);
                        end else begin
                            brow <= brow + 5'd1;
                        end
                    end else begin
                        bcol <= bcol + 6'd1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/m2_pixel_block_fetch.sv
// Fetches 8x8 YUV blocks from SRAM, unpacks pixel pairs into DPRAM, hands blocks to the FDCT.
// Build macro M2_FETCH_PINGPONG_EN: two DPRAM halves so the next block is fetched while one
// is presented; otherwise a single half at 0-63 with strictly sequential fetch/present.
module m2_pixel_block_fetch
    import m2_pixel_block_fetch_pkg::*;
#(
    parameter logic [17:0] Y_BASE      = Y_BASE_DEF,
    parameter logic [17:0] U_BASE      = U_BASE_DEF,
    parameter logic [17:0] V_BASE      = V_BASE_DEF,
    parameter int unsigned LEVEL_SHIFT = 0
)(
    input  logic                 Clock,
    input  logic                 Resetn,
    input  logic                 Enable,
    output logic [ADDR_W-1:0]    SRAM_address,
    input  logic [15:0]          SRAM_read_data,
    output logic                 SRAM_we_n,
    output logic [DP_ADDR_W-1:0] DP_address_a,
    output logic [DP_ADDR_W-1:0] DP_address_b,
    output logic [31:0]          DP_write_data_a,
    output logic [31:0]          DP_write_data_b,
    output logic                 DP_we_a,
    output logic                 DP_we_b,
    output logic                 Block_valid,
    input  logic                 Block_release,
    output logic [INDEX_W-1:0]   Block_index,
    output logic                 Buf_sel,
    output logic                 Busy,
    output logic                 Frame_done
);

    localparam logic SHIFT = 1'(LEVEL_SHIFT != 0);

    state_t                    state;
    logic [4:0]                cnt;
    logic [1:0]                full;
    logic                      rd_buf;
    logic                      wr_buf;
    logic [1:0][INDEX_W-1:0]   idx;

    logic                      v1;
    logic [DP_ADDR_W-1:0]      a1_a;
    logic [DP_ADDR_W-1:0]      a1_b;

    logic [DP_ADDR_W-1:0]      ag_dp_a;
    logic [DP_ADDR_W-1:0]      ag_dp_b;
    logic [INDEX_W-1:0]        ag_block_num;

    logic                      wait_st_c;
    logic                      release_c;
    logic                      fetch_done_c;
    logic                      all_fetched_c;
    logic                      free_c;
    logic                      start_c;
    logic                      issue_c;
    logic                      finish_c;
    logic [1:0]                full_nxt_c;
    logic                      rd_nxt_c;
    logic                      wr_nxt_c;

    assign SRAM_we_n = 1'b1;

    m2_block_addr_gen #(
        .Y_BASE (Y_BASE),
        .U_BASE (U_BASE),
        .V_BASE (V_BASE)
    ) u_addr_gen (
        .Clock        (Clock),
        .Resetn       (Resetn),
        .issue        (issue_c),
        .clear        (finish_c),
        .buf_sel      (wr_buf),
        .sram_address (SRAM_address),
        .dp_address_a (ag_dp_a),
        .dp_address_b (ag_dp_b),
        .block_num    (ag_block_num)
    );

    // Handshake decisions: flag updates, fetch start, frame completion.
    always_comb begin
        wait_st_c     = (state == ST_PUBLISH) || (state == ST_WAIT_RELEASE);
        release_c     = Block_release && Block_valid;
        fetch_done_c  = (state == ST_DRAIN) && (cnt == 5'd1);
        all_fetched_c = (ag_block_num == 12'(TOTAL_BLOCKS));
        full_nxt_c    = full;
        if (release_c) begin
            full_nxt_c[rd_buf] = 1'b0;
        end
        if (fetch_done_c) begin
            full_nxt_c[wr_buf] = 1'b1;
        end
        free_c   = !full[wr_buf] || (release_c && (rd_buf == wr_buf));
        start_c  = ((state == ST_IDLE) && Enable) || (wait_st_c && !all_fetched_c && free_c);
        issue_c  = start_c || ((state == ST_ISSUE) && (cnt != 5'(WORDS_PER_BLOCK - 1)));
        finish_c = wait_st_c && all_fetched_c && (full_nxt_c == 2'b00);
    end

`ifdef M2_FETCH_PINGPONG_EN
    assign rd_nxt_c = rd_buf ^ release_c;
    assign wr_nxt_c = wr_buf ^ fetch_done_c;
`else
    assign rd_nxt_c = 1'b0;
    assign wr_nxt_c = 1'b0;
`endif

    // Fetch sequencer: IDLE -> ISSUE(32) -> DRAIN(2) -> PUBLISH -> WAIT_RELEASE.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            Busy       <= 1'b0;
            Frame_done <= 1'b0;
        end else begin
            Frame_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (Enable) begin
                        state <= ST_ISSUE;
                        cnt   <= '0;
                        Busy  <= 1'b1;
                    end
                end
                ST_ISSUE: begin
                    if (cnt == 5'(WORDS_PER_BLOCK - 1)) begin
                        state <= ST_DRAIN;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 5'd1;
                    end
                end
                ST_DRAIN: begin
                    if (cnt == 5'd1) begin
                        state <= ST_PUBLISH;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 5'd1;
                    end
                end
                ST_PUBLISH, ST_WAIT_RELEASE: begin
                    if (finish_c) begin
                        state      <= ST_IDLE;
                        Busy       <= 1'b0;
                        Frame_done <= 1'b1;
                    end else if (start_c) begin
                        state <= ST_ISSUE;
                        cnt   <= '0;
                    end else begin
                        state <= ST_WAIT_RELEASE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Buffer full flags and the presented-block outputs.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            full        <= '0;
            rd_buf      <= 1'b0;
            wr_buf      <= 1'b0;
            idx         <= '0;
            Block_valid <= 1'b0;
            Block_index <= '0;
            Buf_sel     <= 1'b0;
        end else begin
            full   <= full_nxt_c;
            rd_buf <= rd_nxt_c;
            wr_buf <= wr_nxt_c;
            if (start_c) begin
                idx[wr_buf] <= ag_block_num;
            end
            Block_valid <= full_nxt_c[rd_nxt_c];
            Block_index <= idx[rd_nxt_c];
            Buf_sel     <= rd_nxt_c;
        end
    end

    // Two-stage address-to-data pipe; SRAM data for word n lands with its DP address in cycle n+2.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            v1              <= 1'b0;
            a1_a            <= '0;
            a1_b            <= '0;
            DP_we_a         <= 1'b0;
            DP_we_b         <= 1'b0;
            DP_address_a    <= '0;
            DP_address_b    <= '0;
            DP_write_data_a <= '0;
            DP_write_data_b <= '0;
        end else begin
            v1      <= (state == ST_ISSUE);
            a1_a    <= ag_dp_a;
            a1_b    <= ag_dp_b;
            DP_we_a <= v1;
            DP_we_b <= v1;
            if (v1) begin
                DP_address_a    <= a1_a;
                DP_address_b    <= a1_b;
                DP_write_data_a <= pixel_value(SRAM_read_data[15:8], SHIFT);
                DP_write_data_b <= pixel_value(SRAM_read_data[7:0], SHIFT);
            end
        end
    end

endmodule

// File: tb/tb_m2_pixel_block_fetch.sv
// Directed bench for m2_pixel_block_fetch (single-buffer build), SRAM[w] = w.
module tb_m2_pixel_block_fetch;

    logic        Clock = 1'b0;
    logic        Resetn;
    logic        Enable;
    logic        Block_release;
    logic        ls_enable;

    logic [17:0] SRAM_address;
    logic [15:0] sram_rd;
    logic        SRAM_we_n;
    logic [6:0]  DP_address_a, DP_address_b;
    logic [31:0] DP_write_data_a, DP_write_data_b;
    logic        DP_we_a, DP_we_b;
    logic        Block_valid;
    logic [11:0] Block_index;
    logic        Buf_sel, Busy, Frame_done;

    logic [17:0] ls_addr;
    logic        ls_we_n;
    logic [6:0]  ls_dpa, ls_dpb;
    logic [31:0] ls_da, ls_db;
    logic        ls_wea, ls_web, ls_valid, ls_bufsel, ls_busy, ls_done;
    logic [11:0] ls_index;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 Clock = ~Clock;

    // SRAM model: word w holds w, data valid two edges after the address.
    always @(posedge Clock) sram_rd <= 16'(SRAM_address);

    m2_pixel_block_fetch u_dut (
        .Clock           (Clock),
        .Resetn          (Resetn),
        .Enable          (Enable),
        .SRAM_address    (SRAM_address),
        .SRAM_read_data  (sram_rd),
        .SRAM_we_n       (SRAM_we_n),
        .DP_address_a    (DP_address_a),
        .DP_address_b    (DP_address_b),
        .DP_write_data_a (DP_write_data_a),
        .DP_write_data_b (DP_write_data_b),
        .DP_we_a         (DP_we_a),
        .DP_we_b         (DP_we_b),
        .Block_valid     (Block_valid),
        .Block_release   (Block_release),
        .Block_index     (Block_index),
        .Buf_sel         (Buf_sel),
        .Busy            (Busy),
        .Frame_done      (Frame_done)
    );

    m2_pixel_block_fetch #(.LEVEL_SHIFT(1)) u_ls (
        .Clock           (Clock),
        .Resetn          (Resetn),
        .Enable          (ls_enable),
        .SRAM_address    (ls_addr),
        .SRAM_read_data  (16'h00FF),
        .SRAM_we_n       (ls_we_n),
        .DP_address_a    (ls_dpa),
        .DP_address_b    (ls_dpb),
        .DP_write_data_a (ls_da),
        .DP_write_data_b (ls_db),
        .DP_we_a         (ls_wea),
        .DP_we_b         (ls_web),
        .Block_valid     (ls_valid),
        .Block_release   (1'b0),
        .Block_index     (ls_index),
        .Buf_sel         (ls_bufsel),
        .Busy            (ls_busy),
        .Frame_done      (ls_done)
    );

    function automatic int unsigned exp_addr(input int unsigned b, input int unsigned n);
        int unsigned base, w, cols, lb;
        if (b < 1200) begin
            base = 0;     w = 160; cols = 40; lb = b;
        end else if (b < 1800) begin
            base = 38400; w = 80;  cols = 20; lb = b - 1200;
        end else begin
            base = 57600; w = 80;  cols = 20; lb = b - 1800;
        end
        return base + (lb / cols) * 8 * w + (lb % cols) * 4 + (n / 4) * w + (n % 4);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp)
        else begin
            tests_failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int guard;
        int bad;
        int n;
        int unsigned wa;

        Resetn = 1'b0; Enable = 1'b0; Block_release = 1'b0; ls_enable = 1'b0;
        repeat (3) @(negedge Clock);
        check("rst_addr",  32'(SRAM_address), 32'd0);
        check("rst_we_n",  32'(SRAM_we_n), 32'd1);
        check("rst_busy",  32'(Busy), 32'd0);
        check("rst_valid", 32'(Block_valid), 32'd0);
        check("rst_dp_we", 32'({DP_we_a, DP_we_b}), 32'd0);
        check("rst_done",  32'(Frame_done), 32'd0);
        check("rst_index", 32'(Block_index), 32'd0);

        Resetn = 1'b1;
        @(negedge Clock);
        Enable = 1'b1; ls_enable = 1'b1;
        @(negedge Clock);
        Enable = 1'b0; ls_enable = 1'b0;

        // Block 0, cycle by cycle from ISSUE entry; a stray release and Enable are injected.
        for (int c = 0; c < 35; c++) begin
            if (c < 32) check("blk0_addr", 32'(SRAM_address), 32'(exp_addr(0, c)));
            if (c >= 2 && c <= 33) begin
                n  = c - 2;
                wa = exp_addr(0, n);
                check("blk0_we",    32'({DP_we_a, DP_we_b}), 32'd3);
                check("blk0_dpa",   32'(DP_address_a), 32'((n / 4) * 8 + (n % 4) * 2));
                check("blk0_dpb",   32'(DP_address_b), 32'((n / 4) * 8 + (n % 4) * 2 + 1));
                check("blk0_data_a", DP_write_data_a, 32'((wa >> 8) & 32'hFF));
                check("blk0_data_b", DP_write_data_b, 32'(wa & 32'hFF));
            end else begin
                check("blk0_we_idle", 32'({DP_we_a, DP_we_b}), 32'd0);
            end
            check("blk0_valid", 32'(Block_valid), 32'(c >= 34));
            if (c == 0) check("blk0_busy", 32'(Busy), 32'd1);
            if (c == 2) begin
                check("ls_we",     32'(ls_wea), 32'd1);
                check("ls_data_a", ls_da, 32'hFFFFFF80);
                check("ls_data_b", ls_db, 32'h0000007F);
            end
            Block_release = (c == 10);
            Enable        = (c == 12);
            @(negedge Clock);
        end
        Block_release = 1'b0; Enable = 1'b0;
        check("blk0_index",  32'(Block_index), 32'd0);
        check("blk0_bufsel", 32'(Buf_sel), 32'd0);

        // Withheld release: no address movement, no writes, block stays valid.
        bad = 0;
        repeat (100) begin
            if (SRAM_address != 18'd1123 || DP_we_a || DP_we_b || !Block_valid) bad++;
            @(negedge Clock);
        end
        check("withhold", 32'(bad), 32'd0);

        // Whole frame with immediate releases.
        for (int b = 0; b < 2400; b++) begin
            guard = 0;
            while (!Block_valid && guard < 60) begin
                @(negedge Clock);
                guard++;
            end
            check("valid_timeout", 32'(guard < 60), 32'd1);
            check("blk_index", 32'(Block_index), 32'(b));
            Block_release = 1'b1;
            @(negedge Clock);
            Block_release = 1'b0;
            if (b < 2399) begin
                check("valid_drop", 32'(Block_valid), 32'd0);
                check("first_addr", 32'(SRAM_address), 32'(exp_addr(b + 1, 0)));
                if (b + 1 == 40)   check("blk40_addr",   32'(SRAM_address), 32'd1280);
                if (b + 1 == 1200) check("blk1200_addr", 32'(SRAM_address), 32'd38400);
                if (b + 1 == 1800) check("blk1800_addr", 32'(SRAM_address), 32'd57600);
                if (b + 1 == 2399) begin
                    check("blk2399_first", 32'(SRAM_address), 32'd76236);
                    repeat (31) @(negedge Clock);
                    check("blk2399_last", 32'(SRAM_address), 32'd76799);
                end
            end else begin
                check("frame_done", 32'(Frame_done), 32'd1);
                check("frame_busy", 32'(Busy), 32'd0);
                check("frame_valid", 32'(Block_valid), 32'd0);
                @(negedge Clock);
                check("frame_done_pulse", 32'(Frame_done), 32'd0);
            end
        end

        // Reset in ISSUE cycle 10 of a new frame.
        Enable = 1'b1;
        @(negedge Clock);
        Enable = 1'b0;
        check("restart_addr0", 32'(SRAM_address), 32'd0);
        repeat (10) @(negedge Clock);
        check("issue10_addr", 32'(SRAM_address), 32'd322);
        Resetn = 1'b0;
        #1;
        check("midrst_addr",  32'(SRAM_address), 32'd0);
        check("midrst_we",    32'({DP_we_a, DP_we_b}), 32'd0);
        check("midrst_busy",  32'(Busy), 32'd0);
        check("midrst_we_n",  32'(SRAM_we_n), 32'd1);
        check("midrst_data",  DP_write_data_a | DP_write_data_b, 32'd0);
        bad = 0;
        repeat (3) begin
            @(negedge Clock);
            if (DP_we_a || DP_we_b || Block_valid) bad++;
        end
        Resetn = 1'b1;
        @(negedge Clock);
        if (DP_we_a || DP_we_b) bad++;
        check("midrst_quiet", 32'(bad), 32'd0);
        Enable = 1'b1;
        @(negedge Clock);
        Enable = 1'b0;
        check("rerun_addr0", 32'(SRAM_address), 32'd0);
        check("rerun_busy",  32'(Busy), 32'd1);
        guard = 0;
        while (!Block_valid && guard < 60) begin
            @(negedge Clock);
            guard++;
        end
        check("rerun_latency", 32'(guard), 32'd34);
        check("rerun_index",   32'(Block_index), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
